// File: rtl/timebase_gen.sv
// Programmable base divider followed by a chain of modulo-DIG_MOD digit stages.
// Every output is registered; carries ripple through all digits within one edge.
module timebase_gen #(
  parameter int CNT_W   = 19,
  parameter int NUM_DIG = 3,
  parameter int DIG_MOD = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [CNT_W-1:0]     term_cnt,
  output logic [CNT_W-1:0]     divcnt,
  output logic                 base_tick,
  output logic [NUM_DIG-1:0]   dig_tick,
  output logic [4*NUM_DIG-1:0] digits
);

  logic [CNT_W-1:0]     divcnt_reg;
  logic [CNT_W-1:0]     term_shadow_reg;
  logic                 base_tick_reg;
  logic [NUM_DIG-1:0]   dig_tick_reg;
  logic [4*NUM_DIG-1:0] digits_reg;
  logic [4*NUM_DIG-1:0] digits_next;
  logic [NUM_DIG:0]     carry;
  logic                 base_wrap;

  // The shadow copy, not term_cnt, sets the period, so a new term_cnt
  // only takes effect once the period in progress has wrapped.
  assign base_wrap = en && (divcnt_reg >= term_shadow_reg);
  assign carry[0]  = base_wrap;

  generate
    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_digit
      logic [3:0] cur;
      logic       at_max;
      assign cur        = digits_reg[4*gi +: 4];
      assign at_max     = (cur == 4'(DIG_MOD - 1));
      assign carry[gi+1] = carry[gi] && at_max;
      assign digits_next[4*gi +: 4] = carry[gi] ? (at_max ? 4'd0 : cur + 4'd1) : cur;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      divcnt_reg      <= '0;
      term_shadow_reg <= term_cnt;
      base_tick_reg   <= 1'b0;
      dig_tick_reg    <= '0;
      digits_reg      <= '0;
    end else if (en) begin
      if (base_wrap) begin
        divcnt_reg      <= '0;
        term_shadow_reg <= term_cnt;
        base_tick_reg   <= 1'b1;
      end else begin
        divcnt_reg    <= divcnt_reg + 1'b1;
        base_tick_reg <= 1'b0;
      end
      digits_reg   <= digits_next;
      dig_tick_reg <= carry[NUM_DIG:1];
    end else begin
      base_tick_reg <= 1'b0;
      dig_tick_reg  <= '0;
    end
  end

  assign divcnt    = divcnt_reg;
  assign base_tick = base_tick_reg;
  assign dig_tick  = dig_tick_reg;
  assign digits    = digits_reg;

endmodule

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 Parameter CNT_W, default 19: width of the divider counter and the terminal-count input.
REQ-002 Parameter NUM_DIG, default 3: number of cascaded decimal-style digit stages above the base divider.
REQ-003 Parameter DIG_MOD, default 10, legal range 2..16: modulus of every digit stage.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port en  input  1: count enable; when low, all state holds.
REQ-007 Port clr  input  1: synchronous clear of counters, shadow and ticks.
REQ-008 Port term_cnt  input  CNT_W: terminal count of the base divider (period = term_cnt+1 enabled cycles); 0x7A11F gives a hundredth-second tick at 50 MHz.
REQ-009 Port divcnt  output  CNT_W: current base divider count, registered.
REQ-010 Port base_tick  output  1: one-cycle pulse per base period, registered.
REQ-011 Port dig_tick  output  NUM_DIG: bit k is a one-cycle pulse when digit k wraps, registered.
REQ-012 Port digits  output  4*NUM_DIG: digit k occupies bits [4k+3:4k], registered, unsigned.

Function
REQ-013 An internal term_shadow register (CNT_W) is the only compare value; it is loaded from term_cnt on rst, on clr, and on every base wrap, and at no other time.
REQ-014 When en=1 and clr=0 and divcnt < term_shadow, divcnt increments by 1 at the clock edge.
REQ-015 When en=1 and clr=0 and divcnt >= term_shadow, divcnt becomes 0 (base wrap) and term_shadow reloads.
REQ-016 base_tick is 1 in exactly the cycle following a base-wrap edge, and 0 otherwise.
REQ-017 term_shadow=0: a base wrap occurs on every enabled cycle; base_tick stays high continuously while en=1.
REQ-018 Digit 0 increments on each base wrap; digit k (k>0) increments at the same edge on which digit k-1 wraps.
REQ-019 A digit at DIG_MOD-1 that increments becomes 0 (digit wrap); dig_tick[k] is 1 in the cycle following that edge.
REQ-020 Carries ripple within a single edge: when all digits are DIG_MOD-1 at a base wrap, all digits become 0 together and base_tick and all dig_tick bits are high in the same following cycle.
REQ-021 After the top digit wraps, counting continues from all-zero; there is no saturation or stop.
REQ-022 en=0 (clr=0): divcnt, digits and term_shadow hold; base_tick and dig_tick are 0 in the next cycle.
REQ-023 clr=1: divcnt=0, digits=0, base_tick=0, dig_tick=0, term_shadow=term_cnt at the next edge; clr has priority over en.
REQ-024 A term_cnt change mid-period does not affect the current period; it takes effect from the period after the next base wrap.
REQ-025 Tick outputs are pulses, never stretched; a tick is never produced without a corresponding wrap.

Reset
REQ-026 rst=1 at a clock edge: divcnt=0, digits=0, base_tick=0, dig_tick=0, term_shadow=term_cnt, regardless of en or clr.
REQ-027 rst asserted mid-period or mid-cascade has the same effect as REQ-026; no partial count survives.
REQ-028 After rst deasserts with en=1, the first base_tick follows exactly term_cnt+1 enabled edges.

Verification
REQ-029 term_cnt=4, rst then en=1: divcnt 0,1,2,3,4,0,...; base_tick high every 5th cycle, one cycle wide; digits[3:0] increments per tick.
REQ-030 term_cnt=0x7A11F, en=1 for 500000 cycles after rst: exactly one base_tick, divcnt=0 afterwards, digits=0x001.
REQ-031 term_cnt=0, NUM_DIG=3, DIG_MOD=10, en=1: after 999 edges digits=0x999; next edge digits=0x000 and base_tick=1, dig_tick=3'b111 in the same cycle.
REQ-032 term_cnt=4, en dropped at divcnt=2 for 3 cycles: divcnt holds 2, no ticks; resumes 3,4,0 with base_tick after wrap.
REQ-033 term_cnt=9 running, term_cnt changed to 2 at divcnt=5: counts to 9, wraps, then period of 3 cycles.
REQ-034 clr and rst pulsed at divcnt=3, digits=0x042 with en=1: next cycle divcnt=0, digits=0, all ticks 0.
